// File: rtl/mult_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_pkg;

  // Control FSM states of seq_multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Legal operand widths.
  localparam int MULT_WIDTH_MIN = 2;
  localparam int MULT_WIDTH_MAX = 32;

endpackage : mult_pkg

// File: rtl/seq_mult_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper accumulator half, then shift right.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module seq_mult_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH:0]  acc_i,
  input  logic [WIDTH-1:0]  mcand_i,
  input  logic [WIDTH-1:0]  mplier_i,
  output logic [2*WIDTH:0]  acc_o,
  output logic [WIDTH-1:0]  mplier_o
);

  logic [WIDTH:0]   upper;
  logic [2*WIDTH:0] sum_acc;

  // Add when the current multiplier LSB is set. The top accumulator bit is
  // always 0 after the previous shift, so the W+1-bit sum cannot overflow.
  always_comb begin
    upper = acc_i[2*WIDTH:WIDTH];
    if (mplier_i[0]) begin
      upper = acc_i[2*WIDTH:WIDTH] + {1'b0, mcand_i};
    end
    sum_acc  = {upper, acc_i[WIDTH-1:0]};
    acc_o    = sum_acc >> 1;
    mplier_o = mplier_i >> 1;
  end

endmodule : seq_mult_step

// File: rtl/seq_multiplier.sv
// Sequential WIDTH-cycle shift-add multiplier with optional signed mode (macro SEQ_MULT_SIGNED_EN).
// Latency: out_valid rises WIDTH+1 clocks after the input handshake.
// Backpressure: single-entry; in_ready low in RUN/DONE, product held in DONE until out_ready.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  import mult_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < MULT_WIDTH_MIN || WIDTH > MULT_WIDTH_MAX) begin : g_bad_width
    $error("seq_multiplier: WIDTH out of range");
  end

  state_t               state_q, state_d;
  logic                 init_q;
  logic [2*WIDTH:0]     acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d, mplier_step;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 in_fire;
  logic                 cnt_done;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 neg_q, neg_d;
`else
  logic                 unused_signed_mode;
  assign unused_signed_mode = signed_mode;
`endif

  assign in_fire  = in_valid & in_ready;
  assign cnt_done = (cnt_q == CNT_W'(WIDTH));
  assign product  = product_q;

  seq_mult_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_step),
    .mplier_o (mplier_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
    end
  end

  // Next-state logic: WIDTH iterations, then one extra RUN cycle to load the product.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire)   state_d = RUN;
      RUN:     if (cnt_done)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE) && init_q;
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
  end

  // Datapath next-state: operand capture, iteration, and final (optionally negated) product load.
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
    neg_d     = neg_q;
`endif
    if (state_q == IDLE && in_fire) begin
      acc_d = '0;
      cnt_d = '0;
`ifdef SEQ_MULT_SIGNED_EN
      if (signed_mode) begin
        // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
        mcand_d  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        mplier_d = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
      end else begin
        mcand_d  = a;
        mplier_d = b;
        neg_d    = 1'b0;
      end
`else
      mcand_d  = a;
      mplier_d = b;
`endif
    end else if (state_q == RUN) begin
      if (!cnt_done) begin
        acc_d    = acc_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q + CNT_W'(1);
      end else begin
`ifdef SEQ_MULT_SIGNED_EN
        product_d = neg_q ? (~acc_q[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc_q[2*WIDTH-1:0];
`else
        product_d = acc_q[2*WIDTH-1:0];
`endif
      end
    end
  end

  // Datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

endmodule : seq_multiplier
